// File: rtl/stb_pkg.sv
// Shared types and width helpers for the store buffer.
// Defaults here match the datapath; the modules take these as parameter defaults.
package stb_pkg;

    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;
    localparam int STB_DEPTH  = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int STB_PTR_W = ptr_width(STB_DEPTH);
    localparam int STB_CNT_W = cnt_width(STB_DEPTH);

    typedef logic [STB_PTR_W-1:0] ptr_t;
    typedef logic [STB_CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] data;
    } stb_entry_t;

endpackage

// File: rtl/stb_addr_match.sv
// Compares a load address against every occupied buffer entry and reports
// the youngest matching entry (occupancy walked from head, last match wins).
module stb_addr_match
    import stb_pkg::*;
#(
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DEPTH  = STB_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx
);

    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] idx;

    // Age offset o from head: the entry at head+count-1 (tail-1) is youngest,
    // so iterating oldest-to-youngest and overwriting gives youngest priority.
    always_comb begin
        valid   = '0;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int o = 0; o < DEPTH; o++) begin
            idx        = head + PTR_W'(o);
            valid[idx] = (CNT_W'(o) < count);
            if (valid[idx] && (entry_addr[idx] == ld_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer in front of the single-port data memory; drains when no load owns the port.
// STB_FWD_EN: forward load data from matching queued stores; otherwise stall loads that hit the buffer.
module store_buffer
    import stb_pkg::*;
#(
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DATA_W = STB_DATA_W,
    parameter int DEPTH  = STB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;

    // Ready comes from the registered count only, so a full buffer stalls
    // the store for one cycle even when it drains on the same edge.
    assign st_ready = (count != FULL);
    assign empty    = (count == '0);
    assign push     = st_valid && st_ready;
    assign pop      = !empty && !ld_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_wdata;
        end
    end

    always_comb begin
        mem_we    = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_valid) begin
            mem_addr = ld_addr;
        end else if (pop) begin
            mem_addr  = addr_q[head];
            mem_wdata = data_q[head];
        end
    end

    stb_addr_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match (
        .entry_addr (addr_q),
        .head       (head),
        .count      (count),
        .ld_addr    (ld_addr),
        .hit        (hit),
        .hit_idx    (hit_idx)
    );

`ifdef STB_FWD_EN
    assign ld_rdata = hit ? data_q[hit_idx] : mem_rdata;
    assign ld_stall = 1'b0;
`else
    // Without forwarding the load holds the port while stalled; the datapath
    // must drop ld_valid for the buffer to drain the matching store.
    logic unused_hit_idx;
    assign unused_hit_idx = ^hit_idx;
    assign ld_rdata       = mem_rdata;
    assign ld_stall       = ld_valid && hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table plus multi-cycle sequences,
// checked against a small memory model attached to the memory port.
module tb_store_buffer;
    import stb_pkg::*;

    localparam int DEPTH = STB_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_rdata;
    logic        ld_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        empty;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_rdata  (ld_rdata),
        .ld_stall  (ld_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .empty     (empty)
    );

    // Memory model: combinational read, write on posedge, log of written addresses.
    logic [31:0] mem [256];
    logic [31:0] wlog [$];
    logic        mem_clr = 1'b0;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wlog.push_back(mem_addr);
        end
    end

    typedef struct {
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic        ld_v;
        logic [31:0] ld_a;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_wd;
        logic        e_empty;
    } vec_t;

    function automatic vec_t mk(int sv, int sa, int sd, int lv, int la,
                                int rdy, int we, int ma, int wd, int emp);
        vec_t v;
        v.st_v    = sv[0];
        v.st_a    = sa;
        v.st_d    = sd;
        v.ld_v    = lv[0];
        v.ld_a    = la;
        v.e_rdy   = rdy[0];
        v.e_we    = we[0];
        v.e_maddr = ma;
        v.e_wd    = wd;
        v.e_empty = emp[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_wdata = sd;
        ld_valid = lv;
        ld_addr  = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int nxt;
        int cnt_m;
        int budget;
        logic pu;
        logic po;
        logic [31:0] exp_q [$];

        // Test 1 and test 2 as a cycle table.
        vt[0]  = mk(0, 0,     0,     0, 0,     1, 0, 0,     0,     1);
        vt[1]  = mk(1, 5,     'hA5,  0, 0,     1, 0, 0,     0,     1);
        vt[2]  = mk(0, 0,     0,     0, 0,     1, 1, 5,     'hA5,  0);
        vt[3]  = mk(0, 0,     0,     0, 0,     1, 0, 0,     0,     1);
        vt[4]  = mk(1, 1,     'h101, 1, 'h40,  1, 0, 'h40,  0,     1);
        vt[5]  = mk(1, 2,     'h102, 1, 'h40,  1, 0, 'h40,  0,     0);
        vt[6]  = mk(1, 3,     'h103, 1, 'h40,  1, 0, 'h40,  0,     0);
        vt[7]  = mk(1, 4,     'h104, 1, 'h40,  1, 0, 'h40,  0,     0);
        vt[8]  = mk(1, 5,     'h105, 1, 'h40,  0, 0, 'h40,  0,     0);
        vt[9]  = mk(0, 0,     0,     0, 0,     0, 1, 1,     'h101, 0);
        vt[10] = mk(0, 0,     0,     0, 0,     1, 1, 2,     'h102, 0);
        vt[11] = mk(0, 0,     0,     0, 0,     1, 1, 3,     'h103, 0);
        vt[12] = mk(0, 0,     0,     0, 0,     1, 1, 4,     'h104, 0);
        vt[13] = mk(0, 0,     0,     0, 0,     1, 0, 0,     0,     1);

        drive(0, 0, 0, 0, 0);
        rst     = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_stall", {31'd0, ld_stall}, 32'd0);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].st_v, vt[i].st_a, vt[i].st_d, vt[i].ld_v, vt[i].ld_a);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {31'd0, st_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, vt[i].e_we});
            chk($sformatf("v%0d_maddr", i), mem_addr, vt[i].e_maddr);
            if (vt[i].e_we) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].e_wd);
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e_empty});
            chk($sformatf("v%0d_stall", i), {31'd0, ld_stall}, 32'd0);
            next_cycle();
        end

        chk("t2_wlog_size", wlog.size(), 32'd5);
        if (wlog.size() == 5) begin
            chk("t2_order0", wlog[0], 32'd5);
            chk("t2_order1", wlog[1], 32'd1);
            chk("t2_order2", wlog[2], 32'd2);
            chk("t2_order3", wlog[3], 32'd3);
            chk("t2_order4", wlog[4], 32'd4);
        end
        chk("t1_mem5", mem[5], 32'hA5);
        for (int i = 1; i <= 4; i++) chk($sformatf("t2_mem%0d", i), mem[i], 32'h100 + i);

`ifdef STB_FWD_EN
        // Two stores to the same address; the younger must be forwarded.
        drive(1, 7, 'h11, 1, 'h40);
        next_cycle();
        drive(1, 7, 'h22, 1, 'h40);
        next_cycle();
        drive(0, 0, 0, 1, 7);
        @(negedge clk);
        chk("t3_fwd_data", ld_rdata, 32'h22);
        chk("t3_fwd_stall", {31'd0, ld_stall}, 32'd0);
        chk("t3_fwd_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 1, 5);
        @(negedge clk);
        chk("t3_miss_data", ld_rdata, 32'hA5);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        chk("t3_drained", {31'd0, empty}, 32'd1);
        chk("t3_mem7", mem[7], 32'h22);
`else
        // Matching load stalls and keeps the port until ld_valid drops.
        drive(1, 3, 'h33, 1, 'h40);
        next_cycle();
        drive(0, 0, 0, 1, 3);
        @(negedge clk);
        chk("t4_stall", {31'd0, ld_stall}, 32'd1);
        chk("t4_old_data", ld_rdata, 32'h103);
        chk("t4_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4_stall_hold", {31'd0, ld_stall}, 32'd1);
        chk("t4_we_hold", {31'd0, mem_we}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_drain_we", {31'd0, mem_we}, 32'd1);
        chk("t4_drain_addr", mem_addr, 32'd3);
        chk("t4_drain_data", mem_wdata, 32'h33);
        next_cycle();
        drive(0, 0, 0, 1, 3);
        @(negedge clk);
        chk("t4_reload_stall", {31'd0, ld_stall}, 32'd0);
        chk("t4_reload_data", ld_rdata, 32'h33);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        next_cycle();
`endif

        // Full buffer streamed with continuous stores and no loads.
        base = wlog.size();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 'h10 + i, 'hC00 + i, 1, 'h40);
            exp_q.push_back(32'h10 + i);
            next_cycle();
        end
        nxt    = DEPTH;
        cnt_m  = DEPTH;
        budget = 0;
        while ((nxt < 12 || cnt_m != 0) && budget < 100) begin
            drive(nxt < 12, 'h10 + nxt, 'hC00 + nxt, 0, 0);
            @(negedge clk);
            chk("t5_ready", {31'd0, st_ready}, {31'd0, cnt_m != DEPTH});
            chk("t5_we", {31'd0, mem_we}, {31'd0, cnt_m != 0});
            if (cnt_m != 0) chk("t5_addr", mem_addr, exp_q[0]);
            pu = (nxt < 12) && (cnt_m != DEPTH);
            po = (cnt_m != 0);
            if (po) void'(exp_q.pop_front());
            if (pu) begin
                exp_q.push_back(32'h10 + nxt);
                nxt++;
            end
            cnt_m = cnt_m + int'(pu) - int'(po);
            next_cycle();
            budget++;
        end
        if (budget >= 100) chk("t5_budget", budget, 32'd0);
        chk("t5_empty", {31'd0, empty}, 32'd1);
        chk("t5_writes", wlog.size() - base, 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t5_mem%0d", i), mem[8'h10 + i], 32'hC00 + i);
            if (base + i < wlog.size())
                chk($sformatf("t5_order%0d", i), wlog[base + i], 32'h10 + i);
        end

        // Reset with three stores pending discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h30 + i, 'hD0 + i, 1, 'h40);
            next_cycle();
        end
        base = wlog.size();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_we", {31'd0, mem_we}, 32'd0);
        chk("t6_ready", {31'd0, st_ready}, 32'd1);
        next_cycle();
        rst = 1'b0;
        repeat (4) next_cycle();
        chk("t6_writes", wlog.size() - base, 32'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("t6_mem%0d", i), mem[8'h30 + i], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
